// File: rtl/conv_acc_sequencer.sv
// conv_acc_sequencer
// Shares the convolution accelerator's 6-bit word-addressed slave port between
// the CPU external bus and an internal job engine. The CPU always wins because
// the EXT bus cannot stall. The engine loads LEN operand words from a stream,
// writes START, polls STATUS until done, reads RESULT and offers it on an
// output stream.
// Optional build macro: CONV_SEQ_PERF_EN adds a per-job cycle counter that is
// readable at config address 3. Without it, address 3 reads as zero.
module conv_acc_sequencer #(
    parameter logic [5:0] DATA_BASE    = 6'd0,
    parameter int         DATA_DEPTH   = 32,
    parameter logic [5:0] START_ADDR   = 6'd62,
    parameter logic [5:0] STATUS_ADDR  = 6'd63,
    parameter logic [5:0] RESULT_ADDR  = 6'd61,
    parameter int         POLL_TIMEOUT = 1024
) (
    input  logic        cpu_clk_g,
    input  logic        reset_button,
    input  logic        cpu_en,
    input  logic        cpu_we,
    input  logic [5:0]  cpu_addr,
    input  logic [31:0] cpu_din,
    input  logic        cfg_en,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_addr,
    input  logic [31:0] cfg_wdata,
    output logic [31:0] cfg_rdata,
    input  logic        s_valid,
    input  logic [31:0] s_data,
    output logic        s_ready,
    output logic        m_valid,
    output logic [31:0] m_data,
    input  logic        m_ready,
    output logic        acc_en,
    output logic        acc_we,
    output logic [5:0]  acc_addr,
    output logic [31:0] acc_din,
    input  logic [31:0] acc_dout,
    output logic        busy
);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD   = 3'd1;
    localparam logic [2:0] START  = 3'd2;
    localparam logic [2:0] POLL   = 3'd3;
    localparam logic [2:0] POLL_W = 3'd4;
    localparam logic [2:0] READ   = 3'd5;
    localparam logic [2:0] READ_W = 3'd6;
    localparam logic [2:0] OUT    = 3'd7;

    localparam int            PW         = $clog2(POLL_TIMEOUT + 1);
    localparam logic [PW-1:0] POLL_LIMIT = PW'(POLL_TIMEOUT);
    localparam logic [5:0]    DEPTH_LEN  = 6'(DATA_DEPTH);

    logic [2:0]    state;
    logic [5:0]    idx;
    logic [5:0]    len;
    logic [PW-1:0] poll_cnt;
    logic          auto_mode;
    logic          done;
    logic          timeout_err;
    logic          owner_ff;
    logic [7:0]    job_count;

    logic          eng_en;
    logic          eng_we;
    logic [5:0]    eng_addr;
    logic [31:0]   eng_din;
    logic          grant;
    logic          ctrl_wr;
    logic          go_req;
    logic          clr_req;
    logic [5:0]    len_wr;
    logic [5:0]    idx_next;
    logic [PW-1:0] poll_next;
    logic          poll_expired;
    logic          status_done;
    logic          timeout_fire;
    logic          out_fire;
    logic [31:0]   perf_value;
    logic          unused_cfg_bits;

    assign grant        = !cpu_en;
    assign ctrl_wr      = cfg_en && cfg_we && (cfg_addr == 2'd0);
    assign go_req       = ctrl_wr && cfg_wdata[0] && (state == IDLE);
    assign clr_req      = ctrl_wr && cfg_wdata[2];
    assign len_wr       = (cfg_wdata[5:0] > DEPTH_LEN) ? DEPTH_LEN : cfg_wdata[5:0];
    assign idx_next     = idx + 6'd1;
    assign poll_next    = poll_cnt + PW'(1);
    assign poll_expired = (poll_next == POLL_LIMIT);
    assign status_done  = owner_ff && acc_dout[0];
    assign timeout_fire = poll_expired &&
                          ((state == POLL) || ((state == POLL_W) && !status_done));
    assign out_fire     = (state == OUT) && m_ready;

    assign s_ready  = (state == LOAD) && grant;
    assign busy     = (state != IDLE);
    assign acc_en   = cpu_en | eng_en;
    assign acc_we   = cpu_en ? cpu_we   : eng_we;
    assign acc_addr = cpu_en ? cpu_addr : eng_addr;
    assign acc_din  = cpu_en ? cpu_din  : eng_din;

    assign unused_cfg_bits = &{1'b0, cfg_wdata[31:6]};

    // Build the engine's port request for the current state (issued only when granted).
    always_comb begin
        eng_en   = 1'b0;
        eng_we   = 1'b0;
        eng_addr = 6'd0;
        eng_din  = 32'd0;
        case (state)
            LOAD: begin
                eng_en   = s_valid;
                eng_we   = 1'b1;
                eng_addr = DATA_BASE + idx;
                eng_din  = s_data;
            end
            START: begin
                eng_en   = 1'b1;
                eng_we   = 1'b1;
                eng_addr = START_ADDR;
                eng_din  = 32'd1;
            end
            POLL: begin
                eng_en   = 1'b1;
                eng_addr = STATUS_ADDR;
            end
            READ: begin
                eng_en   = 1'b1;
                eng_addr = RESULT_ADDR;
            end
            default: begin
            end
        endcase
    end

    // Job FSM, config registers, read ownership tracking and result register.
    always_ff @(posedge cpu_clk_g or posedge reset_button) begin
        if (reset_button) begin
            state       <= IDLE;
            idx         <= 6'd0;
            len         <= DEPTH_LEN;
            poll_cnt    <= '0;
            auto_mode   <= 1'b0;
            done        <= 1'b0;
            timeout_err <= 1'b0;
            owner_ff    <= 1'b0;
            job_count   <= 8'd0;
            m_valid     <= 1'b0;
            m_data      <= 32'd0;
        end else begin
            owner_ff <= grant && eng_en && !eng_we;
            if (ctrl_wr) begin
                auto_mode <= cfg_wdata[1];
            end
            if (cfg_en && cfg_we && (cfg_addr == 2'd1)) begin
                len <= len_wr;
            end
            if (clr_req) begin
                done        <= 1'b0;
                timeout_err <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (go_req) begin
                        idx   <= 6'd0;
                        state <= (len == 6'd0) ? START : LOAD;
                    end
                end
                LOAD: begin
                    if (s_valid && grant) begin
                        idx <= idx_next;
                        if (idx_next == len) begin
                            state <= START;
                        end
                    end
                end
                START: begin
                    if (grant) begin
                        poll_cnt <= '0;
                        state    <= POLL;
                    end
                end
                POLL: begin
                    poll_cnt <= poll_next;
                    if (timeout_fire) begin
                        timeout_err <= 1'b1;
                        job_count   <= job_count + 8'd1;
                        state       <= IDLE;
                    end else if (grant) begin
                        state <= POLL_W;
                    end
                end
                POLL_W: begin
                    poll_cnt <= poll_next;
                    if (status_done) begin
                        state <= READ;
                    end else if (timeout_fire) begin
                        timeout_err <= 1'b1;
                        job_count   <= job_count + 8'd1;
                        state       <= IDLE;
                    end else begin
                        state <= POLL;
                    end
                end
                READ: begin
                    if (grant) begin
                        state <= READ_W;
                    end
                end
                READ_W: begin
                    if (owner_ff) begin
                        m_data  <= acc_dout;
                        m_valid <= 1'b1;
                        state   <= OUT;
                    end else begin
                        state <= READ;
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        m_valid   <= 1'b0;
                        done      <= 1'b1;
                        job_count <= job_count + 8'd1;
                        if (auto_mode) begin
                            idx   <= 6'd0;
                            state <= (len == 6'd0) ? START : LOAD;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CONV_SEQ_PERF_EN
    logic [31:0] perf_cnt;
    logic        perf_run;

    assign perf_value = perf_cnt;

    // Count cycles from job launch until the result handshake or a poll timeout, saturating.
    always_ff @(posedge cpu_clk_g or posedge reset_button) begin
        if (reset_button) begin
            perf_cnt <= 32'd0;
            perf_run <= 1'b0;
        end else begin
            if (go_req || clr_req) begin
                perf_cnt <= 32'd0;
            end else if (perf_run && (perf_cnt != 32'hFFFF_FFFF)) begin
                perf_cnt <= perf_cnt + 32'd1;
            end
            if (go_req) begin
                perf_run <= 1'b1;
            end else if (out_fire || timeout_fire) begin
                perf_run <= 1'b0;
            end
        end
    end
`else
    assign perf_value = 32'd0;
`endif

    // Registered config read port; the value is presented one cycle after the request.
    always_ff @(posedge cpu_clk_g or posedge reset_button) begin
        if (reset_button) begin
            cfg_rdata <= 32'd0;
        end else if (cfg_en && !cfg_we) begin
            case (cfg_addr)
                2'd2:    cfg_rdata <= {16'd0, job_count, 5'd0, timeout_err, done, busy};
                2'd3:    cfg_rdata <= perf_value;
                default: cfg_rdata <= 32'd0;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_acc_sequencer.sv
// Directed testbench for conv_acc_sequencer. A small behavioural accelerator
// model answers the acc_* port (registered read data, STATUS done after a
// programmable number of polls, fixed RESULT word) and logs every write.
module tb_conv_acc_sequencer;

    logic        cpu_clk_g    = 1'b0;
    logic        reset_button = 1'b1;
    logic        cpu_en       = 1'b0;
    logic        cpu_we       = 1'b0;
    logic [5:0]  cpu_addr     = 6'd0;
    logic [31:0] cpu_din      = 32'd0;
    logic        cfg_en       = 1'b0;
    logic        cfg_we       = 1'b0;
    logic [1:0]  cfg_addr     = 2'd0;
    logic [31:0] cfg_wdata    = 32'd0;
    logic [31:0] cfg_rdata;
    logic        s_valid      = 1'b0;
    logic [31:0] s_data       = 32'd0;
    logic        s_ready;
    logic        m_valid;
    logic [31:0] m_data;
    logic        m_ready      = 1'b0;
    logic        acc_en;
    logic        acc_we;
    logic [5:0]  acc_addr;
    logic [31:0] acc_din;
    logic [31:0] acc_dout     = 32'd0;
    logic        busy;

    int total = 0;
    int bad   = 0;

    logic [31:0] acc_mem [64];
    int          status_reads   = 0;
    int          done_after     = 0;
    logic [31:0] result_word    = 32'd0;
    int          m_valid_cycles = 0;
    logic [5:0]  wr_addr_log [$];
    logic [31:0] wr_data_log [$];

    conv_acc_sequencer #(.POLL_TIMEOUT(16)) dut (
        .cpu_clk_g    (cpu_clk_g),
        .reset_button (reset_button),
        .cpu_en       (cpu_en),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_din      (cpu_din),
        .cfg_en       (cfg_en),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_wdata    (cfg_wdata),
        .cfg_rdata    (cfg_rdata),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .m_valid      (m_valid),
        .m_data       (m_data),
        .m_ready      (m_ready),
        .acc_en       (acc_en),
        .acc_we       (acc_we),
        .acc_addr     (acc_addr),
        .acc_din      (acc_din),
        .acc_dout     (acc_dout),
        .busy         (busy)
    );

    always #5 cpu_clk_g = ~cpu_clk_g;

    // Accelerator model: writes land in memory and the log, reads return data one cycle later.
    always @(posedge cpu_clk_g) begin
        if (acc_en && acc_we) begin
            acc_mem[acc_addr] <= acc_din;
            wr_addr_log.push_back(acc_addr);
            wr_data_log.push_back(acc_din);
            if (acc_addr == 6'd62) status_reads <= 0;
        end
        if (acc_en && !acc_we) begin
            if (acc_addr == 6'd63) begin
                status_reads <= status_reads + 1;
                acc_dout <= ((done_after != 0) && (status_reads + 1 >= done_after)) ? 32'd1 : 32'd0;
            end else if (acc_addr == 6'd61) begin
                acc_dout <= result_word;
            end else begin
                acc_dout <= acc_mem[acc_addr];
            end
        end
    end

    // Track how many cycles the result stream was offered.
    always @(posedge cpu_clk_g) begin
        if (m_valid) m_valid_cycles <= m_valid_cycles + 1;
    end

    // Hard stop in case something wedges outside the bounded waits.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Config register write lasting one clock, started away from the active edge.
    task automatic applyStimulus(input logic [1:0] addr, input logic [31:0] data);
        cfg_en = 1'b1; cfg_we = 1'b1; cfg_addr = addr; cfg_wdata = data;
        @(negedge cpu_clk_g);
        cfg_en = 1'b0; cfg_we = 1'b0;
    endtask

    task automatic cfgRead(input logic [1:0] addr, output logic [31:0] data);
        cfg_en = 1'b1; cfg_we = 1'b0; cfg_addr = addr;
        @(negedge cpu_clk_g);
        cfg_en = 1'b0;
        #1 data = cfg_rdata;
    endtask

    task automatic sendWord(input logic [31:0] w);
        int n = 0;
        s_valid = 1'b1; s_data = w;
        #1;
        while (!s_ready && n < 20) begin
            @(negedge cpu_clk_g); #1; n++;
        end
        checkOutput("s_ready_wait", 32'(s_ready), 32'd1);
        @(negedge cpu_clk_g);
        s_valid = 1'b0;
    endtask

    task automatic waitValid(input string tag);
        int n = 0;
        #1;
        while (!m_valid && n < 80) begin
            @(negedge cpu_clk_g); #1; n++;
        end
        checkOutput(tag, 32'(m_valid), 32'd1);
    endtask

    task automatic waitEngine(input string tag, input logic we, input logic [5:0] addr);
        int n = 0;
        #1;
        while (!(acc_en && acc_we == we && acc_addr == addr) && n < 40) begin
            @(negedge cpu_clk_g); #1; n++;
        end
        checkOutput(tag, 32'(acc_en && acc_we == we && acc_addr == addr), 32'd1);
    endtask

    task automatic takeResult(input string tag);
        m_ready = 1'b1;
        @(negedge cpu_clk_g);
        m_ready = 1'b0;
        #1 checkOutput(tag, 32'(m_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] rd;
        int          base;
        int          mv_snap;
        int          n;
        logic [5:0]  exp_addr [7];
        logic [31:0] exp_data [7];

        #2;
        checkOutput("rst_s_ready", 32'(s_ready), 32'd0);
        checkOutput("rst_m_valid", 32'(m_valid), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_m_data", m_data, 32'd0);
        checkOutput("rst_cfg_rdata", cfg_rdata, 32'd0);
        checkOutput("rst_acc_en", 32'(acc_en), 32'd0);
        @(negedge cpu_clk_g);
        reset_button = 1'b0;

        $display("[TB] basic job LEN=4");
        result_word = 32'h1E; done_after = 2;
        base = wr_addr_log.size();
        applyStimulus(2'd1, 32'd4);
        applyStimulus(2'd0, 32'd1);
        #1 checkOutput("t1_busy", 32'(busy), 32'd1);
        sendWord(32'd1); sendWord(32'd2); sendWord(32'd3); sendWord(32'd4);
        waitValid("t1_valid");
        checkOutput("t1_m_data", m_data, 32'h1E);
        checkOutput("t1_wr_count", 32'(wr_addr_log.size() - base), 32'd5);
        for (int i = 0; i < 4; i++) begin
            checkOutput("t1_wr_addr", 32'(wr_addr_log[base + i]), 32'(i));
            checkOutput("t1_wr_data", wr_data_log[base + i], 32'(i + 1));
        end
        checkOutput("t1_start_addr", 32'(wr_addr_log[base + 4]), 32'd62);
        checkOutput("t1_start_data", wr_data_log[base + 4], 32'd1);
        takeResult("t1_m_valid_drop");
        cfgRead(2'd2, rd);
        checkOutput("t1_status", rd, 32'h0000_0102);

        $display("[TB] CPU write during LOAD");
        result_word = 32'h55; done_after = 1;
        base = wr_addr_log.size();
        applyStimulus(2'd1, 32'd3);
        applyStimulus(2'd0, 32'd1);
        sendWord(32'hA);
        s_valid = 1'b1; s_data = 32'hB;
        cpu_en = 1'b1; cpu_we = 1'b1; cpu_addr = 6'd5; cpu_din = 32'hCAFE_0004;
        for (int i = 0; i < 3; i++) begin
            #1;
            checkOutput("t2_s_ready_blocked", 32'(s_ready), 32'd0);
            checkOutput("t2_acc_addr", 32'(acc_addr), 32'd5);
            checkOutput("t2_acc_din", acc_din, 32'hCAFE_0004);
            checkOutput("t2_acc_we", 32'(acc_we), 32'd1);
            @(negedge cpu_clk_g);
        end
        cpu_en = 1'b0; cpu_we = 1'b0;
        sendWord(32'hB); sendWord(32'hC);
        waitValid("t2_valid");
        checkOutput("t2_m_data", m_data, 32'h55);
        exp_addr = '{6'd0, 6'd5, 6'd5, 6'd5, 6'd1, 6'd2, 6'd62};
        exp_data = '{32'hA, 32'hCAFE_0004, 32'hCAFE_0004, 32'hCAFE_0004, 32'hB, 32'hC, 32'd1};
        checkOutput("t2_wr_count", 32'(wr_addr_log.size() - base), 32'd7);
        for (int i = 0; i < 7; i++) begin
            checkOutput("t2_wr_addr", 32'(wr_addr_log[base + i]), 32'(exp_addr[i]));
            checkOutput("t2_wr_data", wr_data_log[base + i], exp_data[i]);
        end
        takeResult("t2_m_valid_drop");

        $display("[TB] CPU read right after engine STATUS read");
        result_word = 32'h99; done_after = 1;
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd0, 32'd1);
        waitEngine("t3_status_rd", 1'b0, 6'd63);
        @(negedge cpu_clk_g);
        cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = 6'd5;
        #1;
        checkOutput("t3_engine_sees_status", acc_dout, 32'd1);
        checkOutput("t3_cpu_addr_pass", 32'(acc_addr), 32'd5);
        @(negedge cpu_clk_g);
        cpu_en = 1'b0;
        #1 checkOutput("t3_cpu_data_next", acc_dout, 32'hCAFE_0004);
        waitValid("t3_valid");
        checkOutput("t3_m_data", m_data, 32'h99);
        checkOutput("t3_status_reads", 32'(status_reads), 32'd1);
        takeResult("t3_m_valid_drop");

        $display("[TB] poll timeout");
        done_after = 0;
        mv_snap = m_valid_cycles;
        applyStimulus(2'd0, 32'd1);
        @(negedge cpu_clk_g);
        repeat (15) @(negedge cpu_clk_g);
        #1 checkOutput("t4_busy_before", 32'(busy), 32'd1);
        @(negedge cpu_clk_g);
        #1 checkOutput("t4_busy_after", 32'(busy), 32'd0);
        checkOutput("t4_no_m_valid", 32'(m_valid_cycles - mv_snap), 32'd0);
        cfgRead(2'd2, rd);
        checkOutput("t4_status", rd, 32'h0000_0406);
        applyStimulus(2'd0, 32'd4);
        cfgRead(2'd2, rd);
        checkOutput("t4_status_clr", rd, 32'h0000_0400);

        $display("[TB] AUTO repeat with stalled consumer");
        result_word = 32'h77; done_after = 1;
        applyStimulus(2'd1, 32'd1);
        applyStimulus(2'd0, 32'd3);
        sendWord(32'h11);
        waitValid("t5_valid");
        for (int i = 0; i < 5; i++) begin
            @(negedge cpu_clk_g);
            #1;
            checkOutput("t5_m_data_hold", m_data, 32'h77);
            checkOutput("t5_m_valid_hold", 32'(m_valid), 32'd1);
        end
        m_ready = 1'b1;
        @(negedge cpu_clk_g);
        m_ready = 1'b0;
        n = 0;
        #1;
        while (!s_ready && n < 2) begin
            @(negedge cpu_clk_g); #1; n++;
        end
        checkOutput("t5_s_ready_restart", 32'(s_ready), 32'd1);
        checkOutput("t5_m_valid_drop", 32'(m_valid), 32'd0);
        applyStimulus(2'd0, 32'd0);
        sendWord(32'h22);
        waitValid("t5_valid2");
        checkOutput("t5_m_data2", m_data, 32'h77);
        takeResult("t5_m_valid_drop2");
        checkOutput("t5_idle", 32'(busy), 32'd0);
        cfgRead(2'd2, rd);
        checkOutput("t5_status", rd, 32'h0000_0602);

        $display("[TB] reset during POLL");
        done_after = 0;
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd0, 32'd1);
        waitEngine("t6_status_rd", 1'b0, 6'd63);
        reset_button = 1'b1;
        #1;
        checkOutput("t6_busy", 32'(busy), 32'd0);
        checkOutput("t6_m_valid", 32'(m_valid), 32'd0);
        checkOutput("t6_acc_en", 32'(acc_en), 32'd0);
        checkOutput("t6_s_ready", 32'(s_ready), 32'd0);
        @(negedge cpu_clk_g);
        reset_button = 1'b0;
        cfgRead(2'd2, rd);
        checkOutput("t6_status_rst", rd, 32'd0);
`ifndef CONV_SEQ_PERF_EN
        cfgRead(2'd3, rd);
        checkOutput("t6_perf_zero", rd, 32'd0);
`endif
        result_word = 32'hAB; done_after = 1;
        applyStimulus(2'd1, 32'd0);
        applyStimulus(2'd0, 32'd1);
        #1;
        checkOutput("t6_start_en", 32'(acc_en), 32'd1);
        checkOutput("t6_start_we", 32'(acc_we), 32'd1);
        checkOutput("t6_start_addr", 32'(acc_addr), 32'd62);
        checkOutput("t6_start_din", acc_din, 32'd1);
        waitValid("t6_valid");
        checkOutput("t6_m_data", m_data, 32'hAB);
        takeResult("t6_m_valid_drop");
        cfgRead(2'd2, rd);
        checkOutput("t6_status", rd, 32'h0000_0102);

        $display("[TB] LEN clamps to depth");
        result_word = 32'h3C; done_after = 1;
        applyStimulus(2'd1, 32'd50);
        applyStimulus(2'd0, 32'd1);
        for (int i = 0; i < 32; i++) sendWord(32'(i + 100));
        #1;
        checkOutput("t7_s_ready_off", 32'(s_ready), 32'd0);
        checkOutput("t7_start_addr", 32'(acc_addr), 32'd62);
        checkOutput("t7_start_we", 32'(acc_we), 32'd1);
        waitValid("t7_valid");
        checkOutput("t7_m_data", m_data, 32'h3C);
        takeResult("t7_m_valid_drop");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/conv_acc_sequencer.md
Name: conv_acc_sequencer

Overview:
Sequencer and arbiter for the convolution accelerator's 6-bit word-addressed slave port. It shares that port between the CPU external-bus path and an internal job engine. The engine streams LEN operand words into the accelerator, writes START, polls STATUS, then reads RESULT and presents it on an output stream. It sits between the EXT bus decode and convolution_acc in the FPGA top level.

Parameters:
DATA_BASE, 6'd0, accelerator address of first operand word
DATA_DEPTH, 32, max operand words per job (LEN clamps to this)
START_ADDR, 6'd62, accelerator start register (engine writes 32'd1)
STATUS_ADDR, 6'd63, accelerator status register, bit0 = done
RESULT_ADDR, 6'd61, accelerator result register
POLL_TIMEOUT, 1024, POLL cycles before timeout error

Ports:
cpu_clk_g  in  1  clock
reset_button  in  1  asynchronous, active-high reset
cpu_en  in  1  CPU access to accelerator window
cpu_we  in  1  CPU write strobe
cpu_addr  in  6  CPU word address
cpu_din  in  32  CPU write data
cfg_en  in  1  config register access
cfg_we  in  1  config write strobe
cfg_addr  in  2  config register select
cfg_wdata  in  32  config write data
cfg_rdata  out  32  config read data, registered, 1-cycle latency
s_valid  in  1  operand stream valid
s_data  in  32  operand word
s_ready  out  1  operand accepted this cycle
m_valid  out  1  result valid
m_data  out  32  result word
m_ready  in  1  result consumer ready
acc_en  out  1  to convolution_acc en
acc_we  out  1  to convolution_acc we
acc_addr  out  6  to convolution_acc addr
acc_din  out  32  to convolution_acc din
acc_dout  in  32  from convolution_acc, valid 1 cycle after read
busy  out  1  engine not IDLE

Behaviour:
- Reset (async): FSM to IDLE. s_ready, m_valid, busy, cfg_rdata, m_data, counters, flags all 0. LEN = DATA_DEPTH. Takes effect immediately mid-job; no partial result is emitted.
- Arbitration: CPU has absolute priority because the EXT bus cannot stall. When cpu_en=1, the acc_* outputs are a pass-through of cpu_*, and the engine's request that cycle is not issued and holds its state. Otherwise the acc_* outputs carry the engine's request. When neither requests, acc_en=0. The acc_* outputs are combinational.
- Read ownership: owner_ff records which side issued each read. acc_dout is captured by the engine only when owner_ff = ENGINE.
- Config registers:
  - Address 0, CTRL (write): bit0 GO (self-clearing), bit1 AUTO (repeat), bit2 CLR (clears done and timeout_err).
  - Address 1, LEN (write): [5:0], clamped to DATA_DEPTH.
  - Address 2, STATUS (read): bit0 busy, bit1 done (sticky), bit2 timeout_err (sticky), [15:8] job_count (wraps at 255).
  - Address 3, PERF (read): see Optional Feature.
  - GO while busy is ignored. GO and CLR in the same write: CLR applies first, then the job starts.
- FSM:
  - IDLE: on GO, idx=0, go to LOAD; if LEN=0, go to START instead.
  - LOAD: s_ready=1 only when cpu_en=0. On s_valid&&s_ready, write s_data to DATA_BASE+idx and increment idx. When idx reaches LEN, go to START.
  - START: write 32'd1 to START_ADDR (retried until granted), then go to POLL.
  - POLL: issue a read of STATUS_ADDR, wait 1 cycle in POLL_W, check the engine-owned data.
    - bit0=1: go to READ.
    - Otherwise return to POLL.
    - poll_cnt increments every cycle spent in POLL or POLL_W. When it reaches POLL_TIMEOUT, set timeout_err, increment job_count, and go to IDLE (done not set).
  - READ: read RESULT_ADDR; in READ_W, latch acc_dout into m_data, set m_valid=1, go to OUT.
  - OUT: hold m_data and m_valid until m_ready. On handshake: m_valid=0, done=1, job_count+1, then go to LOAD if AUTO=1 (LOAD entry as from IDLE), else IDLE.
- Address arithmetic: DATA_BASE+idx is 6-bit and wraps modulo 64.
- Stream rules: s_data is never consumed outside LOAD. m_data is stable while m_valid && !m_ready.

Optional Feature:
CONV_SEQ_PERF_EN
- Defined: a 32-bit cycle counter starts on leaving IDLE and freezes on OUT handshake or timeout. It is readable at cfg_addr 3, cleared by CLR or GO, and saturates at 32'hFFFF_FFFF.
- Undefined: no counter logic; cfg_addr 3 reads 32'd0.

Test Plan:
- LEN=4, GO, stream 1,2,3,4 with no CPU traffic, model returns done on 2nd poll and RESULT=32'h1E → acc writes to addr 0..3 then 62; m_data=32'h1E; STATUS done=1, job_count=1.
- cpu_en held high for 3 cycles during LOAD word 2 → s_ready=0 for those cycles; CPU write reaches acc unchanged; no operand dropped or duplicated.
- CPU read of addr 5 issued the cycle after an engine STATUS read → engine sees STATUS data, CPU data follows one cycle later; engine never captures the CPU's data.
- POLL_TIMEOUT=16, model never sets done → timeout_err=1 after 16 poll cycles; busy=0; m_valid never asserted; CLR clears the flag.
- AUTO=1, m_ready held 0 for 5 cycles → m_data stable; after the handshake, LOAD restarts and s_ready rises within 2 cycles.
- reset_button asserted in POLL → busy, m_valid, acc_en (with cpu_en=0) go to 0 immediately; after release, GO with LEN=0 goes directly to the START write.
